// File: rtl/riscv_pkg.sv
// Shared core constants for register-file sizing and the hard-wired zero register.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // x0 reads as zero; writes to it must never reach the array.
    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    // Write-back source identifiers, matching the arbiter's request index.
    typedef enum logic {
        WB_SRC_EXE   = 1'b0,  // ALU / execute path
        WB_SRC_LDCSR = 1'b1   // load / CSR path
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single priority bit.
// Latency: grant is combinational from valid and prio; prio updates on the edge after a grant.
// Backpressure: a requester waits at most one cycle under contention; grants are forced low in reset.
//
// Ports:
//   clk    - clock
//   areset - synchronous active-low reset
//   valid  - request vector, bit N = requester N
//   grant  - one-hot (or zero) grant vector; grant implies valid, so a grant is a transfer
module rr_arb2 (
    input  logic       clk,
    input  logic       areset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // 0 = requester 0 preferred on a tie
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (areset) begin
            if (valid[0] && valid[1]) begin
                grant = prio ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // Prefer the other requester after every transfer. grant[0] set means
    // requester 0 just went, so requester 1 gets preference next.
    always_ff @(posedge clk) begin
        if (!areset) begin
            prio <= 1'b0;
        end else if (|grant) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the execute and load/CSR write-back sources.
// Latency: a write accepted in cycle N drives WE3/A3/WD3 during cycle N+1.
// Backpressure: the write port never stalls, so one source is accepted per cycle; the loser waits at most one cycle.
//
// Ports:
//   clk, areset              - clock, synchronous active-low reset
//   req0_* (valid/addr/data) - execute-path write-back request, req0_ready accepts it
//   req1_* (valid/addr/data) - load/CSR-path write-back request, req1_ready accepts it
//   WE3, A3, WD3             - registered register-file write port
//   wb_src                   - source that owns the current write-port cycle
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_data,
    output logic              req1_ready,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [WIDTH-1:0]  WD3,
    output logic              wb_src
);

    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .areset (areset),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Data/addr only feed the output register, never the readys.
    assign sel_addr = grant[1] ? req1_addr : req0_addr;
    assign sel_data = grant[1] ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (!areset) begin
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            wb_src <= WB_SRC_EXE;
        end else if (|grant) begin
            // x0 writes still complete the handshake but never enable the array.
            WE3    <= (sel_addr != ADDR_W'(X0_ADDR));
            A3     <= sel_addr;
            WD3    <= sel_data;
            wb_src <= grant[1];
        end else begin
            WE3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        areset;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        wb_src;

    int errors = 0;
    int checks = 0;

    // Simple register file behind the write port, for readback checks.
    logic [31:0] rf [32];

    regfile_wb_arbiter #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .areset     (areset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .wb_src     (wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (WE3) rf[A3] <= WD3;
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset     = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got r0=%b r1=%b expected 0 0", i, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0 || wb_src !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got WE3=%b A3=%0d WD3=%h src=%b expected all 0",
                         i, WE3, A3, WD3, wb_src);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        areset     = 1'b1;
        tick();
        checks++;
        if (WE3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_we: got WE3=%b expected 0", WE3);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF || wb_src !== 1'b0) begin
            errors++;
            $display("FAIL single_write: got WE3=%b A3=%0d WD3=%h src=%b expected 1 5 deadbeef 0",
                     WE3, A3, WD3, wb_src);
        end
        tick();
        checks++;
        if (WE3 !== 1'b0 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_idle: got WE3=%b A3=%0d WD3=%h expected 0 5 deadbeef (held)", WE3, A3, WD3);
        end
    endtask

    task automatic test_contention();
        logic exp_src;
        // Restart from reset so prio is 0.
        areset = 1'b0;
        tick();
        areset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h200;
        for (int i = 0; i < 4; i++) begin
            exp_src = i[0];
            #1;
            checks++;
            if (req0_ready !== ~exp_src || req1_ready !== exp_src) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got r0=%b r1=%b expected src %0d", i,
                         req0_ready, req1_ready, exp_src);
            end
            tick();
            checks++;
            if (WE3 !== 1'b1 || A3 !== (exp_src ? 5'd2 : 5'd1) || wb_src !== exp_src ||
                WD3 !== (exp_src ? 32'h200 : 32'h100)) begin
                errors++;
                $display("FAIL contention_write[%0d]: got WE3=%b A3=%0d WD3=%h src=%b expected src %0d",
                         i, WE3, A3, WD3, wb_src, exp_src);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_ready: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (WE3 !== 1'b0 || wb_src !== 1'b1) begin
            errors++;
            $display("FAIL x0_suppress: got WE3=%b src=%b expected 0 1", WE3, wb_src);
        end
        // prio now prefers source 0: look at a tie combinationally only.
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_prio: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_same_addr();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_grant0: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'hA || wb_src !== 1'b0) begin
            errors++;
            $display("FAIL same_first: got WE3=%b A3=%0d WD3=%h src=%b expected 1 7 a 0", WE3, A3, WD3, wb_src);
        end
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_grant1: got r1=%b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'hB || wb_src !== 1'b1) begin
            errors++;
            $display("FAIL same_second: got WE3=%b A3=%0d WD3=%h src=%b expected 1 7 b 1", WE3, A3, WD3, wb_src);
        end
        tick();
        checks++;
        if (rf[7] !== 32'hB) begin
            errors++;
            $display("FAIL same_readback: got x7=%h expected b", rf[7]);
        end
    endtask

    task automatic test_reset_mid();
        // A source-0 transfer moves prio to 1 so the reset has something to undo.
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        tick();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        areset = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_in_reset: got r0=%b expected 0", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        areset = 1'b1;
        checks++;
        if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0 || wb_src !== 1'b0) begin
            errors++;
            $display("FAIL mid_discard: got WE3=%b A3=%0d WD3=%h src=%b expected all 0", WE3, A3, WD3, wb_src);
        end
        tick();
        checks++;
        if (WE3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_late_write: got WE3=%b expected 0", WE3);
        end
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_tie_after_reset: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd4 || wb_src !== 1'b0) begin
            errors++;
            $display("FAIL mid_tie_write: got WE3=%b A3=%0d src=%b expected 1 4 0", WE3, A3, wb_src);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        areset     = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_same_addr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
